// File: rtl/ram_moc_mem.sv
// Byte-addressed big-endian memory with MFA/MOC handshake and programmable wait states.
// Optional macro MEM_ALIGN_CHECK_EN adds AlignErr and suppresses misaligned halfword/word accesses.
module ram_moc_mem #(
  parameter int DEPTH    = 512,
  parameter int ADDR_W   = 9,
  parameter int WAIT_CYC = 2
) (
  input  logic              Clk,
  input  logic              Clear,
  input  logic              MFA,
  input  logic              RW,
  input  logic [1:0]        OpSize,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       DataIn,
  output logic [31:0]       DataOut,
  output logic              MOC,
`ifdef MEM_ALIGN_CHECK_EN
  output logic              AlignErr,
`endif
  output logic              Busy
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [3:0]      WAIT_INIT = 4'(WAIT_CYC);
  localparam logic [ADDR_W:0] DEPTH_W   = (ADDR_W+1)'(DEPTH);

  logic [7:0] Mem [0:DEPTH-1];

  state_t                r_state, w_nstate;
  logic [3:0]            r_cnt;
  logic                  r_rw;
  logic [1:0]            r_size;
  logic [ADDR_W-1:0]     r_addr;
  logic [31:0]           r_data;

  logic [3:0][ADDR_W:0]  w_la;
  logic [3:0]            w_inr;
  logic [3:0]            w_lane_en;
  logic [3:0][7:0]       w_rb;
  logic [3:0][7:0]       w_wb;
  logic [2:0]            w_nb;
  logic [31:0]           w_rdata;
  logic                  w_do_acc;
  logic                  w_wr_en;
  logic                  w_mis;

  assign w_nb = (r_size == 2'b00) ? 3'd1 : (r_size == 2'b01) ? 3'd2 : 3'd4;

  // Lane addresses carry one extra bit so accesses past the top never wrap to 0.
  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign w_la[g]      = {1'b0, r_addr} + (ADDR_W+1)'(g);
    assign w_inr[g]     = (w_la[g] < DEPTH_W);
    assign w_lane_en[g] = w_inr[g] && (3'(g) < w_nb);
    assign w_rb[g]      = w_inr[g] ? Mem[w_la[g][ADDR_W-1:0]] : 8'h00;
  end

  assign w_mis = ((r_size == 2'b01) && r_addr[0]) || (r_size[1] && (r_addr[1:0] != 2'b00));

  always_comb begin
    w_wb    = '0;
    w_rdata = '0;
    case (r_size)
      2'b00: begin
        w_wb[0] = r_data[7:0];
        w_rdata = {24'h0, w_rb[0]};
      end
      2'b01: begin
        w_wb[0] = r_data[15:8];
        w_wb[1] = r_data[7:0];
        w_rdata = {16'h0, w_rb[0], w_rb[1]};
      end
      default: begin
        w_wb    = {r_data[7:0], r_data[15:8], r_data[23:16], r_data[31:24]};
        w_rdata = {w_rb[0], w_rb[1], w_rb[2], w_rb[3]};
      end
    endcase
`ifdef MEM_ALIGN_CHECK_EN
    if (w_mis) w_rdata = '0;
`endif
  end

  assign w_do_acc = (r_state == S_BUSY) && (r_cnt == 4'd0);
`ifdef MEM_ALIGN_CHECK_EN
  assign w_wr_en  = w_do_acc && !r_rw && !w_mis;
`else
  assign w_wr_en  = w_do_acc && !r_rw;
  logic w_unused_mis;
  assign w_unused_mis = w_mis;
`endif

  always_comb begin
    w_nstate = r_state;
    case (r_state)
      S_IDLE:  if (MFA) w_nstate = S_BUSY;
      S_BUSY:  if (r_cnt == 4'd0) w_nstate = S_DONE;
      S_DONE:  if (!MFA) w_nstate = S_IDLE;
      default: w_nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Clear) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_rw     <= 1'b0;
      r_size   <= 2'b00;
      r_addr   <= '0;
      r_data   <= '0;
      MOC      <= 1'b0;
      DataOut  <= '0;
`ifdef MEM_ALIGN_CHECK_EN
      AlignErr <= 1'b0;
`endif
    end else begin
      r_state <= w_nstate;
      // MOC is recomputed every edge, so an external force while idle is simply overwritten.
      MOC     <= (w_nstate == S_DONE);
      if (r_state == S_IDLE && MFA) begin
        r_rw   <= RW;
        r_size <= OpSize;
        r_addr <= Address;
        r_data <= DataIn;
        r_cnt  <= WAIT_INIT;
`ifdef MEM_ALIGN_CHECK_EN
        AlignErr <= 1'b0;
`endif
      end else if (r_state == S_BUSY && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_do_acc && r_rw) DataOut <= w_rdata;
`ifdef MEM_ALIGN_CHECK_EN
      if (w_do_acc && w_mis) AlignErr <= 1'b1;
`endif
    end
  end

  // Storage has no reset; contents survive Clear and can be preloaded hierarchically.
  always_ff @(posedge Clk) begin
    if (Clear && w_wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (w_lane_en[i]) Mem[w_la[i][ADDR_W-1:0]] <= w_wb[i];
      end
    end
  end

  assign Busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_ram_moc_mem.sv
// Scoreboard bench for ram_moc_mem: driver pushes expected responses, monitor checks on MOC rise.
module tb_ram_moc_mem;
  localparam int DEPTH = 512;
  localparam int AW    = 9;
  localparam int WAITC = 2;

  logic          Clk = 1'b0;
  logic          Clear = 1'b0;
  logic          MFA = 1'b0;
  logic          RW = 1'b0;
  logic [1:0]    OpSize = 2'b00;
  logic [AW-1:0] Address = '0;
  logic [31:0]   DataIn = '0;
  logic [31:0]   DataOut;
  logic          MOC;
  logic          Busy;
`ifdef MEM_ALIGN_CHECK_EN
  logic          AlignErr;
`endif

  ram_moc_mem #(.DEPTH(DEPTH), .ADDR_W(AW), .WAIT_CYC(WAITC)) dut (
    .Clk(Clk), .Clear(Clear), .MFA(MFA), .RW(RW), .OpSize(OpSize),
    .Address(Address), .DataIn(DataIn), .DataOut(DataOut), .MOC(MOC),
`ifdef MEM_ALIGN_CHECK_EN
    .AlignErr(AlignErr),
`endif
    .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] data;
    int          issue;
    bit          aerr;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mdl[DEPTH];
  logic [31:0] mdl_dout = '0;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic moc_q = 1'b0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit misal(input logic [1:0] sz, input int a);
`ifdef MEM_ALIGN_CHECK_EN
    if (sz == 2'b01) return (a % 2) != 0;
    if (sz[1])       return (a % 4) != 0;
`endif
    return 1'b0;
  endfunction

  // Monitor: every rising MOC consumes one expected response.
  always @(negedge Clk) begin
    if (MOC && !moc_q) begin
      if (sb.size() == 0) begin
        chk("unexpected_moc", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("dataout", DataOut, e.data);
        chk("latency", 32'(cyc - e.issue), 32'(WAITC + 1));
        chk("busy_at_moc", {31'h0, Busy}, 32'd1);
`ifdef MEM_ALIGN_CHECK_EN
        chk("alignerr", {31'h0, AlignErr}, {31'h0, e.aerr});
`endif
      end
    end
    moc_q = MOC;
  end

  task automatic req(input bit rw, input logic [1:0] sz, input int a,
                     input logic [31:0] d, input int hold);
    exp_t e;
    int   n, t;
    bit   mis;
    n   = nbytes(sz);
    mis = misal(sz, a);
    if (rw) begin
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < n; i++) v = (v << 8) | ((a + i < DEPTH) ? 32'(mdl[a + i]) : 32'h0);
      mdl_dout = mis ? 32'h0 : v;
    end else if (!mis) begin
      for (int i = 0; i < n; i++)
        if (a + i < DEPTH) mdl[a + i] = d[8*(n-1-i) +: 8];
    end
    @(negedge Clk);
    RW = rw; OpSize = sz; Address = AW'(a); DataIn = d; MFA = 1'b1;
    e.data = mdl_dout; e.issue = cyc + 1; e.aerr = mis;
    sb.push_back(e);
    @(negedge Clk);
    // Inputs after acceptance must be ignored.
    Address = AW'($urandom); DataIn = $urandom; RW = 1'($urandom); OpSize = 2'($urandom);
    t = 0;
    while (!MOC && t < 50) begin @(negedge Clk); t++; end
    if (!MOC) chk("moc_timeout", 32'd0, 32'd1);
    for (int h = 0; h < hold; h++) begin
      @(negedge Clk);
      chk("moc_hold", {31'h0, MOC}, 32'd1);
    end
    MFA = 1'b0;
    @(negedge Clk);
    chk("moc_drop", {31'h0, MOC}, 32'd0);
    chk("busy_drop", {31'h0, Busy}, 32'd0);
  endtask

  initial begin
    int bad_mem;
    for (int i = 0; i < DEPTH; i++) begin dut.Mem[i] = 8'h00; mdl[i] = 8'h00; end
    repeat (2) @(negedge Clk);
    chk("rst_moc", {31'h0, MOC}, 32'd0);
    chk("rst_busy", {31'h0, Busy}, 32'd0);
    chk("rst_dout", DataOut, 32'h0);
    Clear = 1'b1;

    dut.Mem[0] = 8'h8C; dut.Mem[1] = 8'h01; dut.Mem[2] = 8'h00; dut.Mem[3] = 8'h04;
    mdl[0] = 8'h8C; mdl[1] = 8'h01; mdl[2] = 8'h00; mdl[3] = 8'h04;
    dut.MOC = 1'b0;
    @(negedge Clk);
    chk("force_moc_idle", {31'h0, Busy}, 32'd0);

    req(1, 2'b10, 0, 32'h0, 0);
    chk("preload_word", mdl_dout, 32'h8C010004);
    req(0, 2'b10, 8, 32'hDEADBEEF, 1);
    req(1, 2'b00, 9, 32'h0, 0);
    chk("byte_rd9", mdl_dout, 32'h000000AD);
    req(1, 2'b01, 10, 32'h0, 0);
    req(0, 2'b00, 511, 32'h0000005A, 0);
    req(1, 2'b10, 510, 32'h0, 0);
    req(0, 2'b10, 100, 32'h12345678, 5);
    req(0, 2'b11, 508, 32'hA1B2C3D4, 2);
    req(1, 2'b11, 508, 32'h0, 0);

    // Reset during BUSY of a word write must abort with no commit.
    dut.Mem[16] = 8'h11; dut.Mem[17] = 8'h22; dut.Mem[18] = 8'h33; dut.Mem[19] = 8'h44;
    mdl[16] = 8'h11; mdl[17] = 8'h22; mdl[18] = 8'h33; mdl[19] = 8'h44;
    @(negedge Clk);
    RW = 1'b0; OpSize = 2'b10; Address = AW'(16); DataIn = 32'hCAFEF00D; MFA = 1'b1;
    @(negedge Clk);
    Clear = 1'b0;
    @(negedge Clk);
    Clear = 1'b1; MFA = 1'b0;
    mdl_dout = 32'h0;
    chk("abort_moc", {31'h0, MOC}, 32'd0);
    chk("abort_busy", {31'h0, Busy}, 32'd0);
    chk("abort_dout", DataOut, 32'h0);
    repeat (4) @(negedge Clk);
    chk("abort_mem", {dut.Mem[16], dut.Mem[17], dut.Mem[18], dut.Mem[19]}, 32'h11223344);

`ifdef MEM_ALIGN_CHECK_EN
    req(0, 2'b10, 2, 32'hFFFFFFFF, 0);
    req(1, 2'b10, 0, 32'h0, 0);
`endif

    for (int k = 0; k < 40; k++) begin
      int a;
      a = ($urandom_range(0, 3) == 0) ? 505 + $urandom_range(0, 6) : $urandom_range(0, DEPTH - 1);
      req(1'($urandom), 2'($urandom), a, $urandom, $urandom_range(0, 2));
    end

    bad_mem = 0;
    for (int i = 0; i < DEPTH; i++) if (dut.Mem[i] !== mdl[i]) bad_mem++;
    chk("mem_final", 32'(bad_mem), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
